// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory command/response bus
// that mem_arbiter shares between them.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
) ();
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DW-1:0]     if_rdata;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DW-1:0]     d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store with a fixed-latency read tag pipeline.
// Define MEM_ARB_RR_EN for round-robin; otherwise data-priority with a starvation guard.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int RLAT       = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mem_arbiter_if.slave bus_io
);
    logic              if_win_s;
    logic              d_win_s;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic              rd_issue_s;
    logic [RLAT-1:0]   tag_vld_q;
    logic [RLAT-1:0]   tag_vld_d;
    logic [RLAT-1:0]   tag_own_q;   // 1 = load/store, 0 = fetch
    logic [RLAT-1:0]   tag_own_d;

`ifdef MEM_ARB_RR_EN
    logic              last_if_q;   // 1 = fetch won the most recent grant
    logic              last_if_d;

    // Round-robin pick: on a tie the side that did not win last goes.
    always_comb begin
        if_win_s = 1'b0;
        d_win_s  = 1'b0;
        if (bus_io.if_req && bus_io.d_req) begin
            if_win_s = ~last_if_q;
            d_win_s  = last_if_q;
        end else begin
            if_win_s = bus_io.if_req;
            d_win_s  = bus_io.d_req;
        end
    end

    // Pointer follows every grant.
    always_comb begin
        last_if_d = last_if_q;
        if (if_gnt_s) begin
            last_if_d = 1'b1;
        end else if (d_gnt_s) begin
            last_if_d = 1'b0;
        end else begin
            last_if_d = last_if_q;
        end
    end

    // Last-winner pointer register; reset state says fetch won last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_if_q <= 1'b1;
        end else begin
            last_if_q <= last_if_d;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0]        starve_q;
    logic [7:0]        starve_d;

    // Data wins unless fetch has watched STARVE_MAX data grants go by.
    always_comb begin
        if_win_s = 1'b0;
        d_win_s  = 1'b0;
        if (bus_io.if_req && (!bus_io.d_req || (starve_q == STARVE_LIM))) begin
            if_win_s = 1'b1;
        end else begin
            d_win_s  = bus_io.d_req;
        end
    end

    // Counter only runs while fetch is waiting, and saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!bus_io.if_req || if_gnt_s) begin
            starve_d = 8'd0;
        end else if (d_gnt_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign if_gnt_s      = if_win_s & rst_ni;
    assign d_gnt_s       = d_win_s & rst_ni;
    assign bus_io.if_gnt = if_gnt_s;
    assign bus_io.d_gnt  = d_gnt_s;

    // Drive the memory command from the winner; idle bus is all zeros.
    always_comb begin
        bus_io.mem_en    = 1'b0;
        bus_io.mem_we    = 1'b0;
        bus_io.mem_addr  = {AW{1'b0}};
        bus_io.mem_wdata = {DW{1'b0}};
        bus_io.mem_be    = {(DW/8){1'b0}};
        if (d_gnt_s) begin
            bus_io.mem_en    = 1'b1;
            bus_io.mem_we    = bus_io.d_we;
            bus_io.mem_addr  = bus_io.d_addr;
            bus_io.mem_wdata = bus_io.d_wdata;
            bus_io.mem_be    = bus_io.d_be;
        end else if (if_gnt_s) begin
            bus_io.mem_en    = 1'b1;
            bus_io.mem_addr  = bus_io.if_addr;
            bus_io.mem_be    = {(DW/8){1'b1}};
        end else begin
            bus_io.mem_en    = 1'b0;
        end
    end

    assign rd_issue_s = bus_io.mem_en & ~bus_io.mem_we;

    // Tag shift: stage 0 records this cycle's read and its owner.
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_own_d = tag_own_q;
        for (int i = RLAT - 1; i > 0; i--) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
        tag_vld_d[0] = rd_issue_s;
        tag_own_d[0] = d_gnt_s;
    end

    // Tag pipeline register; reset drops every in-flight read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q <= {RLAT{1'b0}};
            tag_own_q <= {RLAT{1'b0}};
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
        end
    end

    assign bus_io.if_rvalid = tag_vld_q[RLAT-1] & ~tag_own_q[RLAT-1];
    assign bus_io.d_rvalid  = tag_vld_q[RLAT-1] &  tag_own_q[RLAT-1];
    assign bus_io.if_rdata  = bus_io.if_rvalid ? bus_io.mem_rdata : {DW{1'b0}};
    assign bus_io.d_rdata   = bus_io.d_rvalid  ? bus_io.mem_rdata : {DW{1'b0}};
endmodule
